// File: rtl/note_synth.sv
// note_synth: square-wave tone generator at the pitch of the highest pressed key, phase-continuous with click-free release
module note_synth #(
    parameter int NKEYS     = 27,
    parameter int DIV_W     = 18,
    parameter int DIV_SHIFT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEYS-1:0] note,
    input  logic             enable,
    output logic             audio_out,
    output logic             active,
    output logic [4:0]       note_idx,
    output logic             note_change
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;

    logic [NKEYS-1:0] note_q;
    logic [1:0]       state_q, state_d;
    logic             audio_q, audio_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [4:0]       idx_q, idx_d;
    logic             chg_q, chg_d;
    logic [4:0]       sel;
    logic             go, zero;

    // Half-period in clock cycles for each key, A3 upward, scaled down by DIV_SHIFT and kept at least 1
    function automatic logic [DIV_W-1:0] hp_of(input logic [4:0] k);
        logic [17:0]      rom;
        logic [DIV_W-1:0] v;
        case (k)
            5'd0:    rom = 18'd227273;
            5'd1:    rom = 18'd214517;
            5'd2:    rom = 18'd202477;
            5'd3:    rom = 18'd191113;
            5'd4:    rom = 18'd180386;
            5'd5:    rom = 18'd170262;
            5'd6:    rom = 18'd160706;
            5'd7:    rom = 18'd151686;
            5'd8:    rom = 18'd143173;
            5'd9:    rom = 18'd135137;
            5'd10:   rom = 18'd127553;
            5'd11:   rom = 18'd120394;
            5'd12:   rom = 18'd113636;
            5'd13:   rom = 18'd107258;
            5'd14:   rom = 18'd101238;
            5'd15:   rom = 18'd95556;
            5'd16:   rom = 18'd90193;
            5'd17:   rom = 18'd85131;
            5'd18:   rom = 18'd80353;
            5'd19:   rom = 18'd75843;
            5'd20:   rom = 18'd71586;
            5'd21:   rom = 18'd67569;
            5'd22:   rom = 18'd63776;
            5'd23:   rom = 18'd60197;
            5'd24:   rom = 18'd56818;
            5'd25:   rom = 18'd53629;
            default: rom = 18'd50619;
        endcase
        v = DIV_W'(rom >> DIV_SHIFT);
        return (v == '0) ? DIV_W'(1) : v;
    endfunction

    // Priority encoder: the highest sounding key wins
    always_comb begin
        sel = '0;
        for (int k = 0; k < NKEYS; k++)
            if (note_q[k]) sel = 5'(k);
    end

    assign go   = enable && (note_q != '0);
    assign zero = (cnt_q == '0);

    // Tone FSM: pitch and stop decisions only take effect at waveform edges, except an idle-low stop
    always_comb begin
        state_d = state_q;
        audio_d = audio_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        chg_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_PLAY;
                    idx_d   = sel;
                    cnt_d   = hp_of(sel) - 1'b1;
                    audio_d = 1'b1;
                    chg_d   = 1'b1;
                end
            end
            S_PLAY: begin
                if (zero) begin
                    audio_d = !audio_q;
                    if (!go) begin
                        state_d = audio_q ? S_IDLE : S_REL;
                        cnt_d   = audio_q ? '0 : hp_of(idx_q) - 1'b1;
                    end else begin
                        cnt_d = hp_of(sel) - 1'b1;
                        idx_d = sel;
                        chg_d = (sel != idx_q);
                    end
                end else if (!go) begin
                    state_d = audio_q ? S_REL : S_IDLE;
                    cnt_d   = audio_q ? cnt_q - 1'b1 : '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_REL: begin
                if (zero) begin
                    audio_d = 1'b0;
                    state_d = go ? S_PLAY : S_IDLE;
                    cnt_d   = go ? hp_of(idx_q) - 1'b1 : '0;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = go ? S_PLAY : S_REL;
                end
            end
            default: begin
                state_d = S_IDLE;
                audio_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and input registers; reset silences the output at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            note_q  <= '0;
            state_q <= S_IDLE;
            audio_q <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            chg_q   <= 1'b0;
        end else begin
            note_q  <= note;
            state_q <= state_d;
            audio_q <= audio_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            chg_q   <= chg_d;
        end
    end

    assign audio_out   = audio_q;
    assign active      = (state_q != S_IDLE);
    assign note_idx    = idx_q;
    assign note_change = chg_q;
endmodule

// File: tb/tb_note_synth.sv
// tb_note_synth: randomized and directed stimulus, deadline-based reference model feeding a per-cycle scoreboard
module tb_note_synth;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [26:0] note = '0;
    logic        audio_out, active, note_change;
    logic [4:0]  note_idx;

    int checks = 0;
    int errors = 0;

    note_synth #(.NKEYS(27), .DIV_W(18), .DIV_SHIFT(10)) dut (
        .clk(clk), .reset(reset), .note(note), .enable(enable),
        .audio_out(audio_out), .active(active), .note_idx(note_idx), .note_change(note_change)
    );

    always #5 clk = ~clk;

    // Reference half-period straight from the musical definition
    function automatic int ref_hp(int i);
        real r;
        int  v;
        r = 1.0e8 / (440.0 * (2.0 ** (i / 12.0)));
        v = $rtoi(r + 0.5) >> 10;
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int top_key(logic [26:0] v);
        for (int i = 26; i >= 0; i--)
            if (v[i]) return i;
        return 0;
    endfunction

    // Model state: playing/releasing/idle, output level and the absolute cycle of the next edge
    int          m_state, m_t, m_edge, m_k;
    bit          m_go, m_hit;
    logic        m_audio, m_chg;
    logic [4:0]  m_idx;
    logic [26:0] m_noteq;
    logic [7:0]  q[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state = 0; m_audio = 1'b0; m_idx = '0; m_chg = 1'b0;
            m_noteq = '0; m_t = 0; m_edge = 0;
            q.delete();
            q.push_back(8'h00);
        end else begin
            m_go  = enable && (m_noteq != 0);
            m_k   = top_key(m_noteq);
            m_hit = (m_t == m_edge);
            m_chg = 1'b0;
            if (m_state == 0) begin
                if (m_go) begin
                    m_state = 1; m_idx = 5'(m_k); m_audio = 1'b1; m_chg = 1'b1;
                    m_edge = m_t + ref_hp(m_k);
                end
            end else if (m_state == 1) begin
                if (m_hit) begin
                    m_audio = !m_audio;
                    if (!m_go) begin
                        if (m_audio) begin
                            m_state = 2;
                            m_edge = m_t + ref_hp(int'(m_idx));
                        end else m_state = 0;
                    end else begin
                        m_edge = m_t + ref_hp(m_k);
                        if (m_k != int'(m_idx)) begin
                            m_idx = 5'(m_k);
                            m_chg = 1'b1;
                        end
                    end
                end else if (!m_go) m_state = m_audio ? 2 : 0;
            end else begin
                if (m_hit) begin
                    m_audio = 1'b0;
                    if (m_go) begin
                        m_state = 1;
                        m_edge = m_t + ref_hp(int'(m_idx));
                    end else m_state = 0;
                end else if (m_go) m_state = 1;
            end
            m_noteq = note;
            m_t++;
            q.push_back({m_audio, m_state != 0, m_idx, m_chg});
        end
    end

    // Monitor: every cycle the DUT presents its outputs and one expected entry is consumed
    logic [7:0] exp_e;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_e = q.pop_front();
            checks++;
            if ({audio_out, active, note_idx, note_change} !== exp_e) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t got audio=%b active=%b idx=%0d chg=%b expected audio=%b active=%b idx=%0d chg=%b",
                         $time, audio_out, active, note_idx, note_change,
                         exp_e[7], exp_e[6], exp_e[5:1], exp_e[0]);
            end
        end
    end

    task automatic chk(string nm, int got, int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, expv);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_len(output int n);
        logic l;
        l = audio_out;
        n = 0;
        while (audio_out === l && n < 5000) begin
            tick(1);
            n++;
        end
    endtask

    int n, top;
    logic [26:0] mk;

    initial begin
        note = 27'(1) << 12;
        enable = 1'b1;
        tick(20);
        chk("reset_audio", int'(audio_out), 0);
        chk("reset_active", int'(active), 0);
        reset = 1'b1;
        n = 0;
        while (!active && n < 100) begin tick(1); n++; end
        chk("play_latency", n, 2);
        run_len(n); chk("steady_high", n, ref_hp(12));
        run_len(n); chk("steady_low", n, ref_hp(12));
        chk("steady_idx", int'(note_idx), 12);

        note = 27'(1) | (27'(1) << 26);
        run_len(n); run_len(n); run_len(n);
        chk("prio_half", n, ref_hp(26));
        chk("prio_idx", int'(note_idx), 26);

        note = 27'(1) << 12;
        run_len(n); run_len(n);
        run_len(n); chk("pc_pre", n, ref_hp(12));
        tick(20);
        note = 27'(1);
        run_len(n); chk("pc_cur", n, ref_hp(12) - 20);
        run_len(n); chk("pc_next", n, ref_hp(0));
        chk("pc_idx", int'(note_idx), 0);

        note = 27'(1) << 12;
        run_len(n); run_len(n);
        if (audio_out !== 1'b1) run_len(n);
        tick(30);
        note = '0;
        run_len(n); chk("rel_tail", n, ref_hp(12) - 30);
        chk("rel_active", int'(active), 0);
        chk("rel_audio", int'(audio_out), 0);

        note = 27'(1) << 12;
        n = 0;
        while (audio_out !== 1'b1 && n < 100) begin tick(1); n++; end
        chk("repress_start", n, 2);
        tick(30);
        note = '0;
        tick(10);
        note = 27'(1) << 12;
        run_len(n); chk("repress_high", n, ref_hp(12) - 40);
        chk("repress_active", int'(active), 1);
        run_len(n); chk("repress_low", n, ref_hp(12));

        tick(15);
        reset = 1'b0;
        #1;
        chk("async_audio", int'(audio_out), 0);
        chk("async_active", int'(active), 0);
        tick(3);
        reset = 1'b1;

        for (int s = 0; s < 150; s++) begin
            if ($urandom_range(0, 99) < 10) note = '0;
            else begin
                top  = $urandom_range(0, 26);
                mk   = (27'($urandom) & ((27'(1) << top) - 27'(1))) | (27'(1) << top);
                note = mk;
            end
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) begin
                reset = 1'b0;
                tick(2);
                reset = 1'b1;
            end
            tick($urandom_range(1, 400));
        end
        note = '0;
        tick(300);

        checks++;
        if (checks < 1000) begin
            errors++;
            $display("FAIL check_volume got=%0d expected>=1000", checks);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
